// File: rtl/xilinx_lutram_sdp.sv
// -----------------------------------------------------------------------------
// xilinx_lutram_sdp
//   Simple-dual-port distributed (LUT) RAM, WIDTH x DEPTH, with one write port
//   and one read port. LUTRAM has no native reset, so an optional clear
//   sequencer writes CLEAR_VALUE to every word after reset. Until it has
//   finished, user writes are dropped.
//
//   Parameters
//     WIDTH          data bits per word (>= 1)
//     DEPTH          words, one of 32/64/128/256
//     READ_LATENCY   0 = asynchronous read, 1 = registered read gated by re
//     WRITE_FIRST    registered mode only: same-address read returns new data
//     CLEAR_ON_RESET run the clear sequence after reset
//     CLEAR_VALUE    word written by the clear sequence
//
//   Ports
//     wclk    in   1      clock, all writes and registers on rising edge
//     arst_n  in   1      asynchronous active-low reset
//     we      in   1      write enable, ignored while busy
//     wa      in   AW     write address
//     d       in   WIDTH  write data
//     re      in   1      read enable (registered mode only)
//     ra      in   AW     read address
//     q       out  WIDTH  read data
//     busy    out  1      clear sequence in progress
// -----------------------------------------------------------------------------
module xilinx_lutram_sdp #(
    parameter int                 WIDTH          = 8,
    parameter int                 DEPTH          = 64,
    parameter int                 READ_LATENCY   = 1,
    parameter bit                 WRITE_FIRST    = 1'b1,
    parameter bit                 CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0]   CLEAR_VALUE    = {WIDTH{1'b0}},
    localparam int                AW             = $clog2(DEPTH)
) (
    input  logic             wclk,
    input  logic             arst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] d,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    if (!(DEPTH == 32 || DEPTH == 64 || DEPTH == 128 || DEPTH == 256)) begin : g_bad_depth
        $error("xilinx_lutram_sdp: DEPTH must be 32, 64, 128 or 256");
    end
    if (!(READ_LATENCY == 0 || READ_LATENCY == 1)) begin : g_bad_latency
        $error("xilinx_lutram_sdp: READ_LATENCY must be 0 or 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("xilinx_lutram_sdp: WIDTH must be at least 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // One extra bit so the last address is detected without wrap ambiguity.
    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [AW:0]      clr_addr_r;
    logic             busy_s;
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Clear FSM state register and clear address counter.
    always_ff @(posedge wclk or negedge arst_n) begin
        if (!arst_n) begin
            state_r    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_addr_r <= {(AW+1){1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == ST_CLEAR) begin
                clr_addr_r <= clr_addr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                clr_addr_r <= clr_addr_r;
            end
        end
    end

    // Clear FSM next-state logic; IDLE is held until the next reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_addr_r == LAST_ADDR) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_IDLE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Clear FSM output decode.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            ST_CLEAR: busy_s = 1'b1;
            ST_IDLE:  busy_s = 1'b0;
            default:  busy_s = 1'b0;
        endcase
    end

    assign busy = busy_s;

    // Storage array: deliberately without reset so it maps onto LUTRAM; the
    // clear sequencer owns the write port while busy.
    always_ff @(posedge wclk) begin
        if (busy_s) begin
            mem_r[clr_addr_r[AW-1:0]] <= CLEAR_VALUE;
        end else if (we) begin
            mem_r[wa] <= d;
        end
    end

    if (READ_LATENCY == 0) begin : g_async_read
        // re has no meaning for an asynchronous read port.
        logic unused_re_s;
        assign unused_re_s = re;
        assign q = mem_r[ra];
    end else begin : g_sync_read
        logic [WIDTH-1:0] q_r;

        // Read register in slice flops; while busy it returns CLEAR_VALUE so a
        // partially cleared array never leaks stale contents.
        always_ff @(posedge wclk or negedge arst_n) begin
            if (!arst_n) begin
                q_r <= {WIDTH{1'b0}};
            end else if (re) begin
                if (busy_s) begin
                    q_r <= CLEAR_VALUE;
                end else if (WRITE_FIRST && we && (wa == ra)) begin
                    q_r <= d;
                end else begin
                    q_r <= mem_r[ra];
                end
            end else begin
                q_r <= q_r;
            end
        end

        assign q = q_r;
    end

endmodule
